// File: rtl/icache_core.sv
// -----------------------------------------------------------------------------
// icache_core
// Direct-mapped instruction-cache lookup and refill stage. Sits downstream of
// the AHB transfer handler: one 32-bit instruction word per accepted access,
// upstream stalled (cache_ready low) while a 16-byte line is refilled from the
// memory side in four sequential beats.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   read_addr            word address of the current beat
//   read_addr_offset     byte offset within the line; [3:2] selects the word
//   trans_in             IDLE=0, BUSY=1 (treated as IDLE), NONSEQ=2, SEQ=3
//   flush                invalidate every line (acted on only in IDLE)
//   cache_ready          access accepted this cycle when high (combinational)
//   rdata, rdata_valid   returned word and its one-cycle valid pulse
//   mem_req, mem_addr    line refill request and line-aligned address
//   mem_ack              memory accepted the request
//   mem_rdata, mem_rvalid  refill beat data and valid
//   hit_count, miss_count  saturating 16-bit access statistics
// -----------------------------------------------------------------------------
module icache_core #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_addr,
    input  logic [3:0]  read_addr_offset,
    input  logic [1:0]  trans_in,
    input  logic        flush,
    output logic        cache_ready,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        REFILL,
        RESPOND
    } state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][4];

    // Miss context captured at acceptance; upstream keeps its address
    // stable, but holding our own copy keeps the refill independent of it.
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [1:0]       miss_off;
    logic [1:0]       beat;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- lookup stage (p0): decode the presented beat, probe the arrays ----
    logic [TAG_W-1:0] tag_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [1:0]       off_p0;
    logic             access_p0;
    logic             hit_p0;
    logic             idle_ready;
    logic             accept_p0;
    logic             unused_addr_bits;

    assign tag_p0    = read_addr[31:4+IDX_W];
    assign idx_p0    = read_addr[3+IDX_W:4];
    assign off_p0    = read_addr_offset[3:2];
    assign access_p0 = trans_in[1];   // NONSEQ/SEQ; BUSY and IDLE both have bit1 clear
    assign hit_p0    = valid[idx_p0] && (tag_mem[idx_p0] == tag_p0);

    assign idle_ready  = (state == IDLE) && !flush;
    assign cache_ready = idle_ready;
    assign accept_p0   = access_p0 && idle_ready;
    assign mem_req     = (state == MISS_REQ);

    // Word-granular cache: byte lanes and the low transfer-type bit carry no
    // information here.
    assign unused_addr_bits = ^{read_addr[3:0], read_addr_offset[1:0], trans_in[0]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept_p0 && !hit_p0) state_next = MISS_REQ;
            MISS_REQ: if (mem_ack) state_next = REFILL;
            REFILL:   if (mem_rvalid && beat == 2'd3) state_next = RESPOND;
            RESPOND:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // ---- response stage (p1): registered word, valid pulse, statistics ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            mem_addr    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            beat        <= '0;
        end else begin
            state       <= state_next;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (accept_p0) begin
                        if (hit_p0) begin
                            rdata       <= data_mem[idx_p0][off_p0];
                            rdata_valid <= 1'b1;
                            hit_count   <= sat_inc(hit_count);
                        end else begin
                            // The victim line is overwritten beat by beat, so it
                            // must not look valid if the refill is abandoned.
                            valid[idx_p0] <= 1'b0;
                            mem_addr      <= {tag_p0, idx_p0, 4'b0000};
                            miss_count    <= sat_inc(miss_count);
                        end
                    end
                end
                MISS_REQ: if (mem_ack) beat <= '0;
                REFILL: begin
                    if (mem_rvalid) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            valid[miss_idx] <= 1'b1;
                            rdata_valid     <= 1'b1;
                            // The last beat is still in flight to the array, so
                            // bypass it when it is the requested word.
                            rdata <= (miss_off == 2'd3) ? mem_rdata
                                                        : data_mem[miss_idx][miss_off];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0 && !hit_p0) begin
            miss_tag <= tag_p0;
            miss_idx <= idx_p0;
            miss_off <= off_p0;
        end
        if (state == REFILL && mem_rvalid) begin
            data_mem[miss_idx][beat] <= mem_rdata;
            if (beat == 2'd3) tag_mem[miss_idx] <= miss_tag;
        end
    end

endmodule
